shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one enabled storage register (D flip-flop bank with load enable) between several requesters. Each requester raises a request with its data. The arbiter grants one requester at a time, drives the register's load enable and data mux, and presents the stored value with the owner's index. It sits in front of the enable-flop datapath and replaces per-client enable logic.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: data width of the shared register.
- `IDW`, default 2: owner index width; must satisfy `2**IDW >= NREQ`.
- `MAX_HOLD`, default 8: maximum consecutive GRANT cycles under lock. Used only with `ARB_LOCK_EN`.

Ports:
- `CLK`  in  1: single clock; all state updates on the posedge.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: request, one bit per requester; level-sensitive.
- `din`  in  NREQ*WIDTH: requester data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `lock`  in  NREQ: hold-grant request per requester. Present only with `ARB_LOCK_EN`.
- `gnt`  out  NREQ: registered, one-hot or zero.
- `En`  out  1: load strobe into the shared register, `|(gnt & req)`.
- `Dout`  out  WIDTH: shared register contents.
- `owner`  out  IDW: index of the requester that last wrote `Dout`.
- `valid`  out  1: `Dout` holds written data; high from the first completed write.

## Operation
- Reset values: `gnt=0`, `Dout=0`, `owner=0`, `valid=0`, state IDLE, priority pointer `ptr=NREQ-1` so requester 0 wins first, hold counter 0.
- State IDLE:
  - If `req` is nonzero, select the first set bit searching `ptr+1, ptr+2, …` modulo NREQ.
  - Register the one-hot `gnt` and go to GRANT.
  - If `req` is zero, stay in IDLE with `gnt=0`.
- State GRANT (granted index g):
  - `En = req[g]`.
  - If `req[g]=1`: at the clock edge, `Dout<=din[g]`, `owner<=g`, `valid<=1`, `ptr<=g`.
  - If `req[g]=0` (withdrawn): no write, `ptr` unchanged, `gnt<=0`, go to IDLE.
  - After a write without lock: `gnt<=0`, go to IDLE. No back-to-back grants, so at most one write every 2 cycles.
- Only the granted requester's `din` reaches the register. Data from ungranted requesters is ignored whatever its `req`.
- Round-robin fairness: with every `req` held high, the grant order is 0,1,…,NREQ-1,0,…
- `Dout`, `owner` and `valid` hold their values while no write occurs.
- Reset asserted mid-GRANT: every register is cleared immediately; the in-flight write is lost.

## Timing
- Request-to-grant: `req[i]` high at edge t in IDLE gives `gnt[i]` high after edge t+1 (1 cycle).
- Grant-to-data: `Dout`, `owner` and `valid` update at the edge ending the GRANT cycle. Total 2 cycles from `req` to `Dout`.
- `En` is combinational from `gnt` and `req`, valid within the GRANT cycle.
- Deassertion of `RST_N` is synchronized by the integrator. The block only requires `RST_N` to meet recovery time at `CLK`.

## Configuration
- Macro: `ARB_LOCK_EN`.
- Defined:
  - `lock` port exists.
  - In GRANT, after a write with `lock[g]=1` and hold count < MAX_HOLD-1: stay in GRANT, keep `gnt`, increment the count. Writes then occur every cycle.
  - When the count reaches MAX_HOLD-1, or on lock drop or req drop: release to IDLE and clear the count. `ptr=g` still rotates priority.
  - `lock` of ungranted requesters is ignored.
- Undefined: no `lock` port, no hold counter. Every grant lasts exactly 1 cycle.

## Test plan
- Reset then single request:
  - Stimulus: `RST_N` low gives all outputs 0. Then `req=4'b0100`, `din[2]=8'hA5`.
  - Response: `gnt=4'b0100` at cycle 1, `Dout=8'hA5`, `owner=2`, `valid=1` at cycle 2, then `gnt=0`.
- Round-robin: `req=4'b1111` held, each `din[i]=8'h10+i` → `owner` sequence 0,1,2,3,0 on writes every 2 cycles, `Dout` 10,11,12,13,10.
- Withdrawal: grant requester 1 with `Dout` previously `8'h33`, drop `req[1]` during GRANT → `En=0`, `Dout` stays `8'h33`, next grant still goes to requester 1 if it re-requests.
- Reset mid-operation: assert `RST_N` low in the GRANT cycle → `gnt`, `Dout` and `valid` are 0 immediately, with no edge needed. After release, `req=4'b1111` grants requester 0 first.
- `ARB_LOCK_EN`, `MAX_HOLD=8`:
  - Stimulus: requester 3 holds `req` and `lock`, with `din` incrementing from `8'h00`; requester 0 also requesting.
  - Response: 8 consecutive writes `8'h00..8'h07` with `owner=3`, then `gnt=0` for 1 cycle, then requester 0 granted.
- Build without `ARB_LOCK_EN` → same lock stimulus minus the port; requesters 3 and 0 alternate single writes.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter in front of one shared load-enabled register. Requesters
// raise req with their data. One requester is granted for one cycle, or for a
// run of cycles when ARB_LOCK_EN is defined and the owner holds lock. Its data
// is loaded into the shared register at the end of the grant cycle. The stored
// value is presented together with the index of the requester that wrote it.
//
// Optional feature macro: ARB_LOCK_EN
//   Adds the lock input and a hold counter. While lock is held, the current
//   owner keeps its grant for up to MAX_HOLD back-to-back writes.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   WIDTH    shared register width
//   IDW      owner index width, 2**IDW >= NREQ
//   MAX_HOLD maximum consecutive locked grant cycles (ARB_LOCK_EN only)
//
// Ports
//   CLK    in   clock, all state changes on posedge
//   RST_N  in   asynchronous active-low reset
//   req    in   per-requester level-sensitive request
//   din    in   requester data, requester i at [i*WIDTH +: WIDTH]
//   lock   in   per-requester hold request (ARB_LOCK_EN only)
//   gnt    out  registered grant, one-hot or zero
//   En     out  load strobe of the shared register, |(gnt & req)
//   Dout   out  shared register contents
//   owner  out  index of the requester that last wrote Dout
//   valid  out  Dout holds written data
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int IDW      = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] din,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0]       lock,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic                  En,
   output logic [WIDTH-1:0]      Dout,
   output logic [IDW-1:0]        owner,
   output logic                  valid
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [NREQ-1:0]  gnt_q,   gnt_d;
   logic [IDW-1:0]   ptr_q,   ptr_d;
   logic [WIDTH-1:0] dout_q,  dout_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic             valid_q, valid_d;

`ifdef ARB_LOCK_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0]    hold_q,  hold_d;
   logic             lock_g;
`endif

   // Round-robin pick: first requester strictly above ptr wins, otherwise the
   // lowest requester at or below ptr (the search wraps around).
   logic            hi_found, lo_found, sel_found;
   logic [IDW-1:0]  hi_idx, lo_idx, sel_idx;

   // NOTE: every combinational output gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && (IDW'(i) > ptr_q) && !hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDW'(i);
         end
         if (req[i] && (IDW'(i) <= ptr_q) && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = IDW'(i);
         end
      end
      sel_found = hi_found | lo_found;
      sel_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Decode of the current grant. gnt_q is one-hot, so OR-ing the selected
   // lanes yields the granted index and that requester's data only.
   logic [IDW-1:0]   g_idx;
   logic [WIDTH-1:0] g_data;

   always_comb begin
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            g_idx  = g_idx | IDW'(i);
            g_data = g_data | din[i*WIDTH +: WIDTH];
         end
      end
   end

   assign En = |(gnt_q & req);
`ifdef ARB_LOCK_EN
   // Lock of ungranted requesters is masked out here.
   assign lock_g = |(gnt_q & lock);
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      dout_d  = dout_q;
      owner_d = owner_q;
      valid_d = valid_q;
`ifdef ARB_LOCK_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               gnt_d   = NREQ'(1) << sel_idx;
               state_d = GRANT;
            end else begin
               gnt_d   = '0;
            end
         end
         GRANT: begin
            // Default for this state is release; the locked path overrides it.
            gnt_d   = '0;
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            hold_d  = '0;
`endif
            if (En) begin
               dout_d  = g_data;
               owner_d = g_idx;
               valid_d = 1'b1;
               ptr_d   = g_idx;
`ifdef ARB_LOCK_EN
               if (lock_g && (hold_q < HW'(MAX_HOLD - 1))) begin
                  gnt_d   = gnt_q;
                  state_d = GRANT;
                  hold_d  = hold_q + HW'(1);
               end
`endif
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   // NOTE: the shared data register is reset as well; valid alone would mask
   // it, but Dout is architecturally visible and must read 0 out of reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= IDW'(NREQ - 1);
         dout_q  <= '0;
         owner_q <= '0;
         valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         dout_q  <= dout_d;
         owner_q <= owner_d;
         valid_q <= valid_d;
`ifdef ARB_LOCK_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign gnt   = gnt_q;
   assign Dout  = dout_q;
   assign owner = owner_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
//
// Directed bench for shared_reg_arbiter with NREQ=4, WIDTH=8, IDW=2.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// With ARB_LOCK_EN defined the bench runs the lock-hold scenario; without it,
// it runs the alternating-grant scenario.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  CLK;
   logic                  RST_N;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] din;
`ifdef ARB_LOCK_EN
   logic [NREQ-1:0]       lock;
`endif
   logic [NREQ-1:0]       gnt;
   logic                  En;
   logic [WIDTH-1:0]      Dout;
   logic [IDW-1:0]        owner;
   logic                  valid;

   int checks   = 0;
   int failures = 0;

   shared_reg_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .MAX_HOLD(8)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .req   (req),
      .din   (din),
`ifdef ARB_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .En    (En),
      .Dout  (Dout),
      .owner (owner),
      .valid (valid)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_din(input int i, input logic [7:0] v);
      din[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      req   = '0;
      din   = '0;
`ifdef ARB_LOCK_EN
      lock  = '0;
`endif
      step();
      check("rst_gnt",   32'(gnt),   32'h0);
      check("rst_en",    32'(En),    32'h0);
      check("rst_dout",  32'(Dout),  32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      RST_N = 1'b1;

      // Single request from requester 2.
      req = 4'b0100;
      set_din(2, 8'hA5);
      step();
      check("single_gnt",   32'(gnt),   32'h4);
      check("single_en",    32'(En),    32'h1);
      check("single_valid0",32'(valid), 32'h0);
      step();
      check("single_dout",  32'(Dout),  32'hA5);
      check("single_owner", 32'(owner), 32'h2);
      check("single_valid", 32'(valid), 32'h1);
      check("single_gnt0",  32'(gnt),   32'h0);
      req = '0;
      step();
      check("idle_gnt",     32'(gnt),   32'h0);
      check("idle_hold",    32'(Dout),  32'hA5);

      // Round-robin from reset with everyone requesting.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_din(i, 8'(8'h10 + i));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         int e;
         e = n % NREQ;
         step();
         check($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1 << e));
         step();
         check($sformatf("rr_owner%0d", n), 32'(owner), 32'(e));
         check($sformatf("rr_dout%0d", n),  32'(Dout),  32'(8'h10 + e));
         check($sformatf("rr_gap%0d", n),   32'(gnt),   32'h0);
      end
      req = '0;
      step();

      // Withdrawal: requester 0 stores 0x33 (ptr=0), then requester 1 is
      // granted and drops its request during the grant cycle.
      set_din(0, 8'h33);
      set_din(1, 8'h77);
      set_din(2, 8'h88);
      req = 4'b0001;
      step();
      step();
      check("wd_setup", 32'(Dout), 32'h33);
      req = 4'b0110;
      step();
      check("wd_gnt1", 32'(gnt), 32'h2);
      req = 4'b0100;
      #1;
      check("wd_en0", 32'(En), 32'h0);
      step();
      check("wd_gnt0",  32'(gnt),   32'h0);
      check("wd_dout",  32'(Dout),  32'h33);
      check("wd_owner", 32'(owner), 32'h0);
      // ptr did not move, so requester 1 wins again over requester 2.
      req = 4'b0110;
      step();
      check("wd_regnt", 32'(gnt), 32'h2);
      step();
      check("wd_dout2", 32'(Dout),  32'h77);
      check("wd_own2",  32'(owner), 32'h1);

      // Reset asserted in the middle of a grant cycle.
      req = 4'b1111;
      step();
      check("mr_gnt", 32'(gnt), 32'h4);
      #2;
      RST_N = 1'b0;
      #1;
      check("mr_gnt0",  32'(gnt),   32'h0);
      check("mr_dout0", 32'(Dout),  32'h0);
      check("mr_valid", 32'(valid), 32'h0);
      check("mr_owner", 32'(owner), 32'h0);
      step();
      RST_N = 1'b1;
      step();
      check("mr_first", 32'(gnt), 32'h1);
      req = '0;
      step();

`ifdef ARB_LOCK_EN
      // Requester 3 locks the register for MAX_HOLD writes, then requester 0.
      do_reset();
      req  = 4'b1000;
      lock = 4'b1000;
      set_din(0, 8'hC0);
      set_din(3, 8'h00);
      step();
      check("lk_gnt3", 32'(gnt), 32'h8);
      req = 4'b1001;
      for (int k = 0; k < 8; k++) begin
         set_din(3, 8'(k));
         step();
         check($sformatf("lk_dout%0d", k),  32'(Dout),  32'(k));
         check($sformatf("lk_owner%0d", k), 32'(owner), 32'h3);
         check($sformatf("lk_gnt%0d", k),   32'(gnt),   (k < 7) ? 32'h8 : 32'h0);
      end
      step();
      check("lk_next0", 32'(gnt), 32'h1);
      step();
      check("lk_own0",  32'(owner), 32'h0);
      check("lk_dout0", 32'(Dout),  32'hC0);
`else
      // Requesters 0 and 3 both requesting alternate single writes.
      do_reset();
      set_din(0, 8'hC0);
      set_din(3, 8'hC3);
      req = 4'b1001;
      for (int n = 0; n < 4; n++) begin
         int e;
         e = (n % 2 == 0) ? 0 : 3;
         step();
         check($sformatf("alt_gnt%0d", n),   32'(gnt),   32'(1 << e));
         step();
         check($sformatf("alt_owner%0d", n), 32'(owner), 32'(e));
         check($sformatf("alt_dout%0d", n),  32'(Dout),  (e == 0) ? 32'hC0 : 32'hC3);
         check($sformatf("alt_gap%0d", n),   32'(gnt),   32'h0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
